// File: rtl/multi_react_timer.sv
// Multi-player reaction timer: random-wait start, per-channel ms counters, first-press arbitration.
// Optional false-start detection enabled by defining TIMER_FALSE_START_EN.
module multi_react_timer #(
  parameter  int unsigned N_CH      = 2,
  parameter  int unsigned TIME_W    = 10,
  parameter  int unsigned RAND_W    = 14,
  parameter  int unsigned OVF_LIMIT = 999,
  localparam int unsigned ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [2:0]               machine_state,
  input  logic [RAND_W-1:0]        rand_num,
  input  logic [N_CH-1:0]          press,
  output logic                     signal_start,
  output logic                     signal_cleared,
  output logic                     signal_overflow,
  output logic                     all_done,
  output logic [N_CH*TIME_W-1:0]   react_time,
  output logic [ID_W-1:0]          first_id,
  output logic                     first_valid,
  output logic [N_CH-1:0]          false_start
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CLR_CNT1 = 3'd2,
    ST_START    = 3'd3,
    ST_STORAGE  = 3'd4,
    ST_CLR_CNT2 = 3'd5,
    ST_AVERAGE  = 3'd6,
    ST_COMPARE  = 3'd7
  } state_e;

  localparam logic [TIME_W-1:0] OVF_VAL = TIME_W'(OVF_LIMIT);

  state_e                        st_c;
  logic [N_CH-1:0]               press_rise_c;

  logic [RAND_W-1:0]             wait_cnt_q, wait_cnt_d;
  logic                          signal_start_q, signal_start_d;
  logic                          signal_cleared_q, signal_cleared_d;
  logic                          signal_overflow_q, signal_overflow_d;
  logic                          all_done_q, all_done_d;
  logic                          first_valid_q, first_valid_d;
  logic [ID_W-1:0]               first_id_q, first_id_d;
  logic [N_CH-1:0]               press_q, press_d;
  logic [N_CH-1:0]               done_q, done_d;
  logic [N_CH-1:0]               ovf_q, ovf_d;
  logic [N_CH-1:0]               fs_q, fs_d;
  logic [N_CH-1:0][TIME_W-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0][TIME_W-1:0]   react_q, react_d;

  assign st_c         = state_e'(machine_state);
  assign press_rise_c = press & ~press_q;

  // Next-state logic for the wait counter, channel timers and flags.
  always_comb begin
    logic hit;
    hit               = 1'b0;
    wait_cnt_d        = '0;
    signal_start_d    = 1'b0;
    signal_cleared_d  = 1'b0;
    press_d           = press;
    done_d            = done_q;
    ovf_d             = ovf_q;
    fs_d              = fs_q;
    cnt_d             = cnt_q;
    react_d           = react_q;
    first_id_d        = first_id_q;
    first_valid_d     = first_valid_q;

    case (st_c)
      ST_WAIT: begin
        wait_cnt_d     = (wait_cnt_q == rand_num) ? wait_cnt_q : wait_cnt_q + RAND_W'(1);
        signal_start_d = signal_start_q | (wait_cnt_q == rand_num);
`ifdef TIMER_FALSE_START_EN
        fs_d           = fs_q | (press_rise_c & {N_CH{~signal_start_q}});
`endif
      end
      ST_CLR_CNT1, ST_CLR_CNT2: begin
        signal_cleared_d = 1'b1;
        done_d           = '0;
        ovf_d            = '0;
        fs_d             = '0;
        cnt_d            = '0;
        react_d          = '0;
        first_id_d       = '0;
        first_valid_d    = 1'b0;
      end
      ST_START: begin
        // Ascending scan so the lowest index wins a simultaneous first press.
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (!done_q[i]) begin
            if (fs_q[i]) begin
              done_d[i]  = 1'b1;
              react_d[i] = OVF_VAL;
            end else if (press_rise_c[i]) begin
              done_d[i]  = 1'b1;
              react_d[i] = cnt_q[i];
              if (!first_valid_q && !hit) begin
                hit           = 1'b1;
                first_valid_d = 1'b1;
                first_id_d    = ID_W'(i);
              end
            end else if (cnt_q[i] == OVF_VAL) begin
              done_d[i]  = 1'b1;
              ovf_d[i]   = 1'b1;
              react_d[i] = OVF_VAL;
            end else begin
              cnt_d[i]   = cnt_q[i] + TIME_W'(1);
            end
          end
        end
      end
      default: ;
    endcase

    all_done_d        = &done_d;
    signal_overflow_d = |ovf_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q        <= '0;
      signal_start_q    <= 1'b0;
      signal_cleared_q  <= 1'b0;
      signal_overflow_q <= 1'b0;
      all_done_q        <= 1'b0;
      first_valid_q     <= 1'b0;
      first_id_q        <= '0;
      press_q           <= '0;
      done_q            <= '0;
      ovf_q             <= '0;
      fs_q              <= '0;
      cnt_q             <= '0;
      react_q           <= '0;
    end else begin
      wait_cnt_q        <= wait_cnt_d;
      signal_start_q    <= signal_start_d;
      signal_cleared_q  <= signal_cleared_d;
      signal_overflow_q <= signal_overflow_d;
      all_done_q        <= all_done_d;
      first_valid_q     <= first_valid_d;
      first_id_q        <= first_id_d;
      press_q           <= press_d;
      done_q            <= done_d;
      ovf_q             <= ovf_d;
      fs_q              <= fs_d;
      cnt_q             <= cnt_d;
      react_q           <= react_d;
    end
  end

  assign signal_start    = signal_start_q;
  assign signal_cleared  = signal_cleared_q;
  assign signal_overflow = signal_overflow_q;
  assign all_done        = all_done_q;
  assign react_time      = react_q;
  assign first_id        = first_id_q;
  assign first_valid     = first_valid_q;
  assign false_start     = fs_q;

endmodule

// File: tb/tb_multi_react_timer.sv
// Bench for multi_react_timer: directed and randomized reaction runs against a press-schedule model.
module tb_multi_react_timer;

  localparam int OVF   = 999;
  localparam int NEVER = 1000000;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CLR1 = 3'd2, S_START = 3'd3,
                         S_CLR2 = 3'd5;

  logic        clk;
  logic        rstn;
  logic [2:0]  machine_state;
  logic [13:0] rand_num;
  logic [1:0]  press;
  logic        signal_start, signal_cleared, signal_overflow, all_done, first_valid;
  logic [19:0] react_time;
  logic [0:0]  first_id;
  logic [1:0]  false_start;

  int n_checks = 0;
  int n_fail   = 0;

  multi_react_timer dut (
    .clk             (clk),
    .rstn            (rstn),
    .machine_state   (machine_state),
    .rand_num        (rand_num),
    .press           (press),
    .signal_start    (signal_start),
    .signal_cleared  (signal_cleared),
    .signal_overflow (signal_overflow),
    .all_done        (all_done),
    .react_time      (react_time),
    .first_id        (first_id),
    .first_valid     (first_valid),
    .false_start     (false_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    machine_state = S_IDLE;
    repeat (n) step();
  endtask

  // Button level before START edge e: held from the clear until rel, then pressed from k on.
  function automatic logic lvl(input int rel, input int k, input int e);
    return (e < rel) || (e >= k);
  endfunction

  function automatic int first_rise(input int rel, input int k, input int t);
    for (int e = 1; e <= t; e++)
      if (lvl(rel, k, e) && !lvl(rel, k, e - 1)) return e;
    return 0;
  endfunction

  function automatic logic [27:0] all_outs();
    return {signal_start, signal_cleared, signal_overflow, all_done,
            react_time, first_id, first_valid, false_start};
  endfunction

  task automatic do_clear(input int rel0, input int rel1);
    machine_state = S_CLR1;
    press = {lvl(rel1, NEVER, 0), lvl(rel0, NEVER, 0)};
    step();
    check("clr_cleared_hi", signal_cleared, 1);
    check("clr_react_zero", react_time, 0);
    check("clr_all_done", all_done, 0);
  endtask

  task automatic run_start(input int t, input int rel0, input int k0, input int rel1, input int k1);
    machine_state = S_START;
    for (int e = 1; e <= t; e++) begin
      press = {lvl(rel1, k1, e), lvl(rel0, k0, e)};
      step();
      if (e == 1) check("start_cleared_lo", signal_cleared, 0);
    end
    machine_state = S_IDLE;
  endtask

  // Expected results from the press schedule: a rise at START edge k captures k-1,
  // otherwise the ceiling is reached on edge OVF+1.
  task automatic check_results(input int t, input int rel0, input int k0, input int rel1, input int k1);
    int kr[2];
    int exp_react[2];
    bit exp_done[2];
    bit exp_ovf[2];
    int best;
    kr[0] = first_rise(rel0, k0, t);
    kr[1] = first_rise(rel1, k1, t);
    best = -1;
    for (int c = 0; c < 2; c++) begin
      exp_react[c] = 0; exp_done[c] = 0; exp_ovf[c] = 0;
      if (kr[c] != 0 && kr[c] <= OVF + 1) begin
        exp_react[c] = kr[c] - 1; exp_done[c] = 1;
        if (best < 0 || kr[c] < kr[best]) best = c;
      end else if (t >= OVF + 1) begin
        exp_react[c] = OVF; exp_done[c] = 1; exp_ovf[c] = 1;
      end
    end
    check("react_ch0", react_time[9:0], exp_react[0]);
    check("react_ch1", react_time[19:10], exp_react[1]);
    check("signal_overflow", signal_overflow, exp_ovf[0] | exp_ovf[1]);
    check("all_done", all_done, exp_done[0] & exp_done[1]);
    check("first_valid", first_valid, best >= 0);
    if (best >= 0) check("first_id", first_id, best);
    check("false_start_zero", false_start, 0);
  endtask

  initial begin
    int r, t, rel0, k0, rel1, k1;
    rstn = 1'b0; machine_state = S_IDLE; rand_num = '0; press = '0;

    // Reset and release
    repeat (5) step();
    check("reset_outputs", all_outs(), 0);
    rstn = 1'b1;
    #2;
    check("release_no_toggle", all_outs(), 0);
    step();
    check("after_release", all_outs(), 0);

    // Random-wait start with rand_num = 38
    machine_state = S_WAIT; rand_num = 14'd38;
    for (int e = 1; e <= 60; e++) begin
      step();
      check("sig_start_38", signal_start, e >= 39);
    end
    idle(1);
    check("sig_start_exit", signal_start, 0);

    // Randomized wait lengths, including zero
    for (int it = 0; it < 3; it++) begin
      r = (it == 0) ? 0 : int'($urandom_range(1, 40));
      rand_num = 14'(r);
      machine_state = S_WAIT;
      for (int e = 1; e <= r + 3; e++) begin
        step();
        check("sig_start_rand", signal_start, e >= r + 1);
      end
      idle(1);
      check("sig_start_rand_exit", signal_start, 0);
    end

    // CLR_CNT2 pulse
    check("cleared_idle", signal_cleared, 0);
    machine_state = S_CLR2;
    step();
    check("cleared_pulse", signal_cleared, 1);
    idle(1);
    check("cleared_drop", signal_cleared, 0);

    // Two presses at 250 and 400
    do_clear(0, 0);
    run_start(450, 0, 251, 0, 401);
    check_results(450, 0, 251, 0, 401);

    // Simultaneous press at count 120
    idle(2);
    do_clear(0, 0);
    run_start(150, 0, 121, 0, 121);
    check_results(150, 0, 121, 0, 121);

    // Held level into START must be released and re-pressed
    idle(2);
    do_clear(51, 0);
    run_start(100, 51, 71, 0, 30);
    check_results(100, 51, 71, 0, 30);

    // Press on the ceiling edge wins over overflow; other channel overflows
    idle(2);
    do_clear(0, 0);
    run_start(1005, 0, 1000, 0, 1001);
    check_results(1005, 0, 1000, 0, 1001);
    check("ceiling_no_ovf_ch0", react_time[9:0], OVF);

    // No presses: overflow on edge 1000, frozen across a non-START gap
    idle(2);
    do_clear(0, 0);
    run_start(999, 0, NEVER, 0, NEVER);
    check("ovf_pre_edge", signal_overflow, 0);
    check("ovf_pre_done", all_done, 0);
    check("ovf_pre_react", react_time, 0);
    idle(3);
    run_start(1, 0, NEVER, 0, NEVER);
    check_results(1000, 0, NEVER, 0, NEVER);
    run_start(10, 0, NEVER, 0, NEVER);
    check("ovf_hold_react", react_time, {10'(OVF), 10'(OVF)});
    check("ovf_hold_flag", signal_overflow, 1);

    // Randomized press schedules
    for (int it = 0; it < 4; it++) begin
      rel0 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : 0;
      rel1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : 0;
      k0   = int'($urandom_range(1, 1100));
      k1   = ($urandom_range(0, 3) == 0) ? k0 : int'($urandom_range(1, 1100));
      t    = int'($urandom_range(950, 1100));
      idle(2);
      press = '0;
      do_clear(rel0, rel1);
      run_start(t, rel0, k0, rel1, k1);
      check_results(t, rel0, k0, rel1, k1);
    end

    // Press during WAIT before start
    idle(2);
    do_clear(0, 0);
    machine_state = S_WAIT; rand_num = 14'd38;
    for (int e = 1; e <= 20; e++) begin
      press = {(e >= 10 && e < 13), 1'b0};
      step();
    end
    check("fs_sig_start_low", signal_start, 0);
`ifdef TIMER_FALSE_START_EN
    check("false_start_set", false_start, 2'b10);
    run_start(60, 0, 51, 0, NEVER);
    check("fs_react_ch0", react_time[9:0], 50);
    check("fs_react_ch1", react_time[19:10], OVF);
    check("fs_no_ovf", signal_overflow, 0);
    check("fs_all_done", all_done, 1);
    check("fs_first_valid", first_valid, 1);
    check("fs_first_id", first_id, 0);
    check("fs_sticky", false_start, 2'b10);
`else
    check("false_start_off", false_start, 0);
    run_start(60, 0, 51, 0, 22);
    check_results(60, 0, 51, 0, 22);
`endif

    // Asynchronous reset mid-START
    idle(2);
    press = '0;
    do_clear(0, 0);
    run_start(500, 0, 101, 0, NEVER);
    machine_state = S_START;
    check("pre_reset_react", react_time[9:0], 100);
    #2 rstn = 1'b0;
    #1 check("async_reset", all_outs(), 0);
    #2 rstn = 1'b1;
    #1 check("reset_release_mid", all_outs(), 0);
    machine_state = S_IDLE;
    step();
    check("reset_after_edge", all_outs(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
